ps2_serial_terminal: RTL and testbench
======================================

Name: ps2_serial_terminal

Overview:
Keyboard-to-serial bridge that feeds the Altair machine's serial receive line (`rx`), so the emulated 2SIO console can be typed into from the MiSTer PS/2 stream.
- Decodes `ps2_key` events from hps_io into ASCII, applying Shift and Ctrl.
- Buffers characters in a small FIFO.
- Serialises each character as 8N1 at a fixed baud on the `CLK_50M` domain.
- Sits between hps_io and the machine, in parallel with front_panel.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud).
- FIFO_DEPTH, 16, character buffer entries; power of two, ≥2.
- FORCE_UPPER, 1, when 1, unshifted letters emit uppercase (Altair BASIC convention).

Ports:
- clk  input  1  system clock (CLK_50M).
- reset  input  1  synchronous, active-high reset.
- ps2_key  input  11  [10] toggles per event, [9] 1=press/0=release, [8] extended (E0), [7:0] scancode.
- enable  input  1  0 = discard new keystrokes; the FIFO keeps draining.
- tx  output  1  serial line to machine rx; idle high.
- busy  output  1  1 while a frame (start..stop) is on tx.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  characters queued.
- overflow  output  1  sticky; set when a character is dropped because the FIFO is full.

Behaviour:
- All state, including the output registers, is cleared on the clock edge where reset=1.
- Reset values: tx=1, busy=0, fifo_count=0, overflow=0, shift=0, ctrl=0, FIFO pointers=0, UART state=IDLE.
- Reset mid-frame aborts the frame: tx=1 on the cycle after reset is sampled.
- Event detect:
  - Register ps2_key[10]; an event occurs when it differs from the registered copy.
  - The first sample after reset seeds the register and is not an event.
- Modifiers, tracked on both press and release:
  - shift = L-shift 0x12 or R-shift 0x59 held (separate flags, ORed).
  - ctrl = 0x14 held, with or without E0.
- Character generation:
  - Only press events with enable=1 that are not modifiers generate characters.
  - Releases of non-modifier keys are ignored.
  - Extended keys are ignored, except keypad Enter (E0 5A), which maps to 0x0D.
- Mapping:
  - Letters a–z (scancode set 2). Output is uppercase if shift XOR FORCE_UPPER... Correction, the rule is: uppercase if (shift | FORCE_UPPER); lowercase only when FORCE_UPPER=0 and shift=0.
  - Digits and US-layout punctuation, with shifted variants (e.g. 0x16 → '1' / '!').
  - Space 0x29 → 0x20, Enter 0x5A → 0x0D, Backspace 0x66 → 0x08, Esc 0x76 → 0x1B, Tab 0x0D → 0x09.
  - Unmapped scancodes produce nothing.
  - With ctrl held and a letter key, the output is (uppercase letter & 0x1F), e.g. Ctrl+C → 0x03. Ctrl with a non-letter key emits the normal mapping.
- Latency from event to FIFO write: 2 clk (detect, lookup/write).
- FIFO:
  - Write when a character is generated. If full, drop the character and set overflow.
  - Read when UART is IDLE and the FIFO is non-empty.
  - Simultaneous read and write while full is still an overflow: the write is evaluated before the read frees a slot.
  - Simultaneous read and write at count 0 is impossible, because a read requires a non-empty FIFO.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is exact.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. On a non-empty FIFO, pop the byte into the shift register → START, busy=1.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles → STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles → IDLE, busy=0.
  - Back-to-back frames: the next START begins on the cycle after STOP ends; there is exactly one IDLE cycle between frames.
  - Bit counter is 3 bits. The cycle counter counts 0..CLKS_PER_BIT-1.
- overflow clears only on reset.

Decomposition:
- Package altair_kbd_pkg holds:
  - scancode constants SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_ENTER, SC_BKSP, SC_ESC, SC_TAB, SC_SPACE;
  - typedef enum uart_state_t {IDLE, START, DATA, STOP};
  - ASCII constants CR, BS, ESC.
- Sub-module ps2_ascii_rom is a combinational lookup:
  - inputs: scancode, shift, force_upper;
  - outputs: ascii[7:0], valid, is_letter.
- FIFO and UART live in ps2_serial_terminal.

Test Plan:
1. Reset, then toggle ps2_key with press 0x1C (FORCE_UPPER=1) → one frame of 0x41. tx low 5208 cycles, then bits 1,0,0,0,0,0,1,0 at 5208 cycles each, then high. busy is 1 for 10×5208 cycles.
2. Press 0x12, press 0x16, release 0x16, release 0x12, press 0x16 → frames 0x21 then 0x31. Releases generate no frames.
3. Press 0x14, press 0x21 ('c') → single frame 0x03. Press E0 5A → 0x0D. Press E0 75 (up arrow) → nothing, fifo_count stays 0.
4. Issue 20 presses of 0x1C within 100 cycles → fifo_count peaks at 16 and overflow=1. The first byte is already popped before later writes arrive, so exactly 17 frames of 0x41 are emitted. Frames are separated by exactly 1 idle cycle.
5. Assert reset mid-DATA of a frame → tx=1 and busy=0 the next cycle, fifo_count=0, overflow=0. No further frames.
6. enable=0 while pressing 0x1C → no frame. A queued character enqueued before enable fell still transmits completely.

Source files
------------

// File: rtl/altair_kbd_pkg.sv
// Shared constants and types for the PS/2-to-serial keyboard bridge.
package altair_kbd_pkg;

  // PS/2 scancode set 2 codes with special handling
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  // ASCII control characters
  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [7:0] HT  = 8'h09;
  localparam logic [7:0] SP  = 8'h20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Shift and Ctrl keys only update modifier state, they never emit a character.
  // E0 12 is a fake shift inside some extended sequences, so shifts must be plain.
  function automatic logic is_modifier(input logic [7:0] code, input logic ext);
    return ((code == SC_LSHIFT || code == SC_RSHIFT) && !ext) || (code == SC_CTRL);
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational scancode (set 2, US layout) to ASCII lookup.
module ps2_ascii_rom
  import altair_kbd_pkg::*;
(
  input  logic [7:0] scancode,
  input  logic       shift,
  input  logic       force_upper,
  output logic [7:0] ascii,
  output logic       valid,
  output logic       is_letter
);

  logic [7:0] letter;
  logic [7:0] plain;
  logic [7:0] shft;

  // Table lookup: letters carry only the lowercase code, other keys a plain/shifted pair
  always_comb begin
    letter = 8'h00;
    plain  = 8'h00;
    shft   = 8'h00;
    case (scancode)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      8'h16: begin plain = "1";  shft = "!";  end
      8'h1E: begin plain = "2";  shft = "@";  end
      8'h26: begin plain = "3";  shft = "#";  end
      8'h25: begin plain = "4";  shft = "$";  end
      8'h2E: begin plain = "5";  shft = "%";  end
      8'h36: begin plain = "6";  shft = "^";  end
      8'h3D: begin plain = "7";  shft = "&";  end
      8'h3E: begin plain = "8";  shft = "*";  end
      8'h46: begin plain = "9";  shft = "(";  end
      8'h45: begin plain = "0";  shft = ")";  end
      8'h0E: begin plain = 8'h60; shft = "~";  end
      8'h4E: begin plain = "-";  shft = "_";  end
      8'h55: begin plain = "=";  shft = "+";  end
      8'h54: begin plain = "[";  shft = "{";  end
      8'h5B: begin plain = "]";  shft = "}";  end
      8'h5D: begin plain = "\\"; shft = "|";  end
      8'h4C: begin plain = ";";  shft = ":";  end
      8'h52: begin plain = "'";  shft = "\""; end
      8'h41: begin plain = ",";  shft = "<";  end
      8'h49: begin plain = ".";  shft = ">";  end
      8'h4A: begin plain = "/";  shft = "?";  end
      SC_SPACE: begin plain = SP;  shft = SP;  end
      SC_ENTER: begin plain = CR;  shft = CR;  end
      SC_BKSP:  begin plain = BS;  shft = BS;  end
      SC_ESC:   begin plain = ESC; shft = ESC; end
      SC_TAB:   begin plain = HT;  shft = HT;  end
      default: ;
    endcase
  end

  // Case selection: letters go uppercase when shifted or when forced upper
  always_comb begin
    is_letter = (letter != 8'h00);
    valid     = is_letter || (plain != 8'h00);
    if (is_letter)
      ascii = (shift || force_upper) ? (letter - 8'h20) : letter;
    else
      ascii = shift ? shft : plain;
  end

endmodule

// File: rtl/ps2_serial_terminal.sv
// PS/2 keystrokes -> ASCII -> FIFO -> 8N1 UART line into the machine's serial rx.
//
// UART states:
//   state | meaning
//   IDLE  | tx high; pops the next FIFO byte when one is queued
//   START | tx low for one bit time
//   DATA  | eight data bits, LSB first, one bit time each
//   STOP  | tx high for one bit time, then back to IDLE
module ps2_serial_terminal
  import altair_kbd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 16,
  parameter bit FORCE_UPPER  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [10:0]                   ps2_key,
  input  logic                          enable,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] CNT_LAST = TW'(CLKS_PER_BIT - 1);

  // key event pipeline and modifier flags
  logic       seeded_q, seeded_d;
  logic       tog_q, tog_d;
  logic       evt_q, evt_d;
  logic       press_q, press_d;
  logic       ext_q, ext_d;
  logic [7:0] code_q, code_d;
  logic       en_q, en_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       ctrl_q, ctrl_d;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  // UART
  uart_state_t   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic [7:0] rom_ascii;
  logic       rom_valid;
  logic       rom_letter;
  logic       gen;
  logic [7:0] gen_char;
  logic       wr_en;
  logic       rd_en;
  logic       last_cnt;

  ps2_ascii_rom u_rom (
    .scancode    (code_q),
    .shift       (lshift_q | rshift_q),
    .force_upper (FORCE_UPPER),
    .ascii       (rom_ascii),
    .valid       (rom_valid),
    .is_letter   (rom_letter)
  );

  // Stage 1: detect a toggle of ps2_key[10] and capture the event fields
  always_comb begin
    seeded_d = 1'b1;
    tog_d    = ps2_key[10];
    evt_d    = seeded_q && (ps2_key[10] != tog_q);
    press_d  = ps2_key[9];
    ext_d    = ps2_key[8];
    code_d   = ps2_key[7:0];
    en_d     = enable;
  end

  // Stage 2: update modifiers and form the character to enqueue
  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    ctrl_d   = ctrl_q;
    if (evt_q) begin
      if (!ext_q && code_q == SC_LSHIFT) lshift_d = press_q;
      if (!ext_q && code_q == SC_RSHIFT) rshift_d = press_q;
      if (code_q == SC_CTRL)             ctrl_d   = press_q;
    end
    gen = evt_q && press_q && en_q && !is_modifier(code_q, ext_q)
          && (ext_q ? (code_q == SC_ENTER) : rom_valid);
    if (ext_q)
      gen_char = CR;
    else if (ctrl_q && rom_letter)
      gen_char = rom_ascii & 8'h1F;
    else
      gen_char = rom_ascii;
  end

  // FIFO bookkeeping: a write into a full FIFO is dropped even if a read happens the same cycle
  always_comb begin
    rd_en      = (state_q == IDLE) && (count_q != '0);
    wr_en      = gen && (count_q != FULL_CNT);
    overflow_d = overflow_q || (gen && (count_q == FULL_CNT));
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(wr_en) - CW'(rd_en);
  end

  // UART next-state; tx/busy are registered from the next state so they line up with state_q
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    last_cnt = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (rd_en) begin
          state_d = START;
          sh_d    = mem_q[rd_ptr_q];
          cnt_d   = '0;
        end
      end
      START: begin
        if (last_cnt) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (last_cnt) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      seeded_q   <= 1'b0;
      tog_q      <= 1'b0;
      evt_q      <= 1'b0;
      press_q    <= 1'b0;
      ext_q      <= 1'b0;
      code_q     <= '0;
      en_q       <= 1'b0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      ctrl_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      seeded_q   <= seeded_d;
      tog_q      <= tog_d;
      evt_q      <= evt_d;
      press_q    <= press_d;
      ext_q      <= ext_d;
      code_q     <= code_d;
      en_q       <= en_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      ctrl_q     <= ctrl_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // FIFO storage; contents are only visible through the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= gen_char;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_serial_terminal.sv
// Directed bench: expected bytes queued at key press, checked by a serial-line receiver.
module tb_ps2_serial_terminal;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        enable;
  logic        tx;
  logic        busy;
  logic [4:0]  fifo_count;
  logic        overflow;

  ps2_serial_terminal #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .FORCE_UPPER  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .enable     (enable),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb[$];
  logic       tog = 1'b0;

  int         mon_phase = 0;
  int         mon_cnt = 0;
  int         frames_seen = 0;
  logic       mon_abort = 1'b0;
  logic       expect_next = 1'b0;
  logic [7:0] rx_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic press, input logic ext, input logic [7:0] code);
    @(negedge clk);
    tog = ~tog;
    ps2_key = {tog, press, ext, code};
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (!(sb.size() == 0 && mon_phase == 0 && !busy && fifo_count == 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n < max), 1);
  endtask

  // Serial receiver: checks bit timing, busy window and the byte against the scoreboard
  task automatic monitor();
    int k, r;
    forever begin
      @(negedge clk);
      if (mon_abort) begin
        mon_phase   = 0;
        expect_next = 1'b0;
        mon_abort   = 1'b0;
      end else if (!reset) begin
        if (mon_phase == 0) begin
          if (expect_next) begin
            chk("b2b_one_idle", tx, 0);
            expect_next = 1'b0;
          end
          if (tx == 1'b0) begin
            mon_phase = 1;
            mon_cnt   = 0;
            rx_byte   = 8'h00;
          end
        end else begin
          mon_cnt++;
        end
        if (mon_phase == 1) begin
          k = mon_cnt / CPB;
          r = mon_cnt % CPB;
          if (k < 10 && (r == 0 || r == CPB - 1)) begin
            chk("busy_in_frame", busy, 1);
            if (k == 0) chk("start_bit", tx, 0);
            else if (k == 9) chk("stop_bit", tx, 1);
            else if (sb.size() != 0) chk("data_bit", tx, sb[0][k-1]);
          end
          if (k >= 1 && k <= 8 && r == CPB / 2) rx_byte[k-1] = tx;
          if (mon_cnt == 10 * CPB) begin
            chk("busy_after_frame", busy, 0);
            chk("tx_after_frame", tx, 1);
            chk("unexpected_frame", (sb.size() != 0), 1);
            if (sb.size() != 0) chk("frame_byte", rx_byte, sb.pop_front());
            frames_seen++;
            expect_next = (fifo_count != 0);
            mon_phase = 0;
          end
        end
      end
    end
  endtask

  initial begin
    int f0;
    int n;
    fork
      monitor();
    join_none

    reset = 1'b1; ps2_key = '0; enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);

    // 1: plain 'a' with forced uppercase -> 'A'
    sb.push_back(8'h41);
    key(1, 0, 8'h1C);
    key(0, 0, 8'h1C);
    wait_drain(1000);
    chk("t1_frames", frames_seen, 1);

    // 2: shifted digit, releases silent, then unshifted digit
    sb.push_back(8'h21);
    sb.push_back(8'h31);
    key(1, 0, 8'h12);
    key(1, 0, 8'h16);
    key(0, 0, 8'h16);
    key(0, 0, 8'h12);
    key(1, 0, 8'h16);
    key(0, 0, 8'h16);
    wait_drain(2000);
    // punctuation with right shift
    sb.push_back(8'h3D);
    sb.push_back(8'h5F);
    key(1, 0, 8'h55);
    key(1, 0, 8'h59);
    key(1, 0, 8'h4E);
    key(0, 0, 8'h59);
    wait_drain(2000);
    chk("t2_frames", frames_seen, 5);

    // 3: Ctrl+C, keypad Enter under ctrl, up arrow ignored
    sb.push_back(8'h03);
    key(1, 0, 8'h14);
    key(1, 0, 8'h21);
    key(0, 0, 8'h21);
    wait_drain(1000);
    sb.push_back(8'h0D);
    key(1, 1, 8'h5A);
    key(0, 1, 8'h5A);
    wait_drain(1000);
    key(1, 1, 8'h75);
    chk("t3_arrow_count", fifo_count, 0);
    chk("t3_arrow_busy", busy, 0);
    key(0, 1, 8'h75);
    key(0, 0, 8'h14);
    repeat (5) @(negedge clk);
    chk("t3_frames", frames_seen, 7);

    // 4: burst of 20 presses overflows a 16-entry FIFO
    chk("t4_overflow_before", overflow, 0);
    f0 = frames_seen;
    for (int i = 0; i < 17; i++) sb.push_back(8'h41);
    for (int i = 0; i < 20; i++) key(1, 0, 8'h1C);
    chk("t4_peak_count", fifo_count, DEPTH);
    chk("t4_overflow", overflow, 1);
    wait_drain(17 * 11 * CPB + 500);
    chk("t4_frames", frames_seen - f0, 17);
    chk("t4_overflow_sticky", overflow, 1);

    // 5: reset in the middle of the data bits
    sb.push_back(8'h41);
    sb.push_back(8'h41);
    key(1, 0, 8'h1C);
    key(1, 0, 8'h1C);
    n = 0;
    while (!(mon_phase == 1 && mon_cnt >= 5 * CPB) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_mid_data_timeout", (n < 2000), 1);
    f0 = frames_seen;
    reset = 1'b1;
    mon_abort = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("t5_tx", tx, 1);
    chk("t5_busy", busy, 0);
    chk("t5_count", fifo_count, 0);
    chk("t5_overflow", overflow, 0);
    repeat (30 * CPB) @(negedge clk);
    chk("t5_no_frames", frames_seen - f0, 0);
    chk("t5_line_idle", mon_phase, 0);

    // 6: keystrokes discarded while disabled, queued byte still sent
    f0 = frames_seen;
    sb.push_back(8'h41);
    sb.push_back(8'h41);
    key(1, 0, 8'h1C);
    key(1, 0, 8'h1C);
    enable = 1'b0;
    key(1, 0, 8'h1C);
    key(1, 0, 8'h1C);
    chk("t6_count", fifo_count, 1);
    wait_drain(3000);
    chk("t6_frames", frames_seen - f0, 2);
    enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
